// File: rtl/cpu_pkg.sv
// Shared widths, opcode and ALU-operation constants, and instruction field
// positions for the 8-bit CPU.
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int OPC_W   = 4;
    localparam int INSTR_W = OPC_W + 2 * DATA_W;

    localparam int OPC_MSB = INSTR_W - 1;
    localparam int OPC_LSB = 2 * DATA_W;
    localparam int OP1_MSB = 2 * DATA_W - 1;
    localparam int OP1_LSB = DATA_W;
    localparam int OP2_MSB = DATA_W - 1;
    localparam int OP2_LSB = 0;

    localparam logic [OPC_W-1:0] OPC_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OPC_XOR  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_LDR  = 4'h8;
    localparam logic [OPC_W-1:0] OPC_NOP  = 4'h9;
    localparam logic [OPC_W-1:0] OPC_STOP = 4'hF;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NOTA = 3'd5,
        ALU_SHL  = 3'd6,
        ALU_SHR  = 3'd7
    } alu_op_e;

endpackage

// File: rtl/dp_alu.sv
// Combinational 8-bit ALU with carry/no-borrow and signed-overflow flags.
module dp_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow
);

    logic [DATA_W:0] sum_add;
    logic [DATA_W:0] sum_sub;

    // Subtraction as a + ~b + 1, so the carry out doubles as "no borrow".
    assign sum_add = {1'b0, a} + {1'b0, b};
    assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD: begin
                result   = sum_add[DATA_W-1:0];
                cout     = sum_add[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                           (sum_add[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result   = sum_sub[DATA_W-1:0];
                cout     = sum_sub[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                           (sum_sub[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOTA: result = ~a;
            ALU_SHL: begin
                result   = {a[DATA_W-2:0], 1'b0};
                cout     = a[DATA_W-1];
                overflow = a[DATA_W-1] ^ a[DATA_W-2];
            end
            ALU_SHR: begin
                result = {a[DATA_W-1], a[DATA_W-1:1]};
                cout   = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_datapath_slice.sv
// Datapath slice of the 8-bit CPU: instruction register with decoded fields,
// combinational ALU and two load-enabled accumulators.
module cpu_datapath_slice
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ir_load_en,
    input  logic [INSTR_W-1:0] ir_instruction_in,
    output logic [OPC_W-1:0]   ir_opcode,
    output logic [DATA_W-1:0]  ir_operand1,
    output logic [DATA_W-1:0]  ir_operand2,
    input  logic [DATA_W-1:0]  alu_in_a,
    input  logic [DATA_W-1:0]  alu_in_b,
    input  logic [2:0]         alu_op,
    output logic [DATA_W-1:0]  alu_result,
    output logic               alu_cout,
    output logic               alu_overflow,
    input  logic               acc1_load_en,
    input  logic [DATA_W-1:0]  acc1_data_in,
    output logic [DATA_W-1:0]  acc1_data_out,
    input  logic               acc2_load_en,
    input  logic [DATA_W-1:0]  acc2_data_in,
    output logic [DATA_W-1:0]  acc2_data_out
);

    // All three fields are captured from one word so they never mix instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_opcode   <= '0;
            ir_operand1 <= '0;
            ir_operand2 <= '0;
        end else if (ir_load_en) begin
            ir_opcode   <= ir_instruction_in[OPC_MSB:OPC_LSB];
            ir_operand1 <= ir_instruction_in[OP1_MSB:OP1_LSB];
            ir_operand2 <= ir_instruction_in[OP2_MSB:OP2_LSB];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1_data_out <= '0;
        end else if (acc1_load_en) begin
            acc1_data_out <= acc1_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc2_data_out <= '0;
        end else if (acc2_load_en) begin
            acc2_data_out <= acc2_data_in;
        end
    end

    dp_alu u_alu (
        .a        (alu_in_a),
        .b        (alu_in_b),
        .op       (alu_op),
        .result   (alu_result),
        .cout     (alu_cout),
        .overflow (alu_overflow)
    );

endmodule

// File: tb/tb_cpu_datapath_slice.sv
// Scoreboard-driven bench for cpu_datapath_slice: expected values are queued
// as stimulus is applied and compared when the DUT output is sampled.
module tb_cpu_datapath_slice;

    logic        clk;
    logic        rst_n;
    logic        ir_load_en;
    logic [19:0] ir_instruction_in;
    logic [3:0]  ir_opcode;
    logic [7:0]  ir_operand1;
    logic [7:0]  ir_operand2;
    logic [7:0]  alu_in_a;
    logic [7:0]  alu_in_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic        alu_overflow;
    logic        acc1_load_en;
    logic [7:0]  acc1_data_in;
    logic [7:0]  acc1_data_out;
    logic        acc2_load_en;
    logic [7:0]  acc2_data_in;
    logic [7:0]  acc2_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] exp_q[$];
    string       name_q[$];

    cpu_datapath_slice dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ir_load_en        (ir_load_en),
        .ir_instruction_in (ir_instruction_in),
        .ir_opcode         (ir_opcode),
        .ir_operand1       (ir_operand1),
        .ir_operand2       (ir_operand2),
        .alu_in_a          (alu_in_a),
        .alu_in_b          (alu_in_b),
        .alu_op            (alu_op),
        .alu_result        (alu_result),
        .alu_cout          (alu_cout),
        .alu_overflow      (alu_overflow),
        .acc1_load_en      (acc1_load_en),
        .acc1_data_in      (acc1_data_in),
        .acc1_data_out     (acc1_data_out),
        .acc2_load_en      (acc2_load_en),
        .acc2_data_in      (acc2_data_in),
        .acc2_data_out     (acc2_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full registered state packed as {opcode, op1, op2, acc1, acc2}.
    function automatic logic [35:0] reg_state();
        return {ir_opcode, ir_operand1, ir_operand2, acc1_data_out, acc2_data_out};
    endfunction

    task automatic test_reset();
        logic [35:0] exp;
        logic [35:0] obs;
        string       nm;
        @(negedge clk);
        ir_load_en        = 1'b1;
        acc1_load_en      = 1'b1;
        acc2_load_en      = 1'b1;
        ir_instruction_in = 20'hF_FF_FF;
        acc1_data_in      = 8'hFF;
        acc2_data_in      = 8'hFF;
        #2;
        rst_n = 1'b0;
        exp_q.push_back('0);
        name_q.push_back("reset_async");
        #1;
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        obs = reg_state();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        exp_q.push_back('0);
        name_q.push_back("reset_held_over_edge");
        @(negedge clk);
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        obs = reg_state();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        ir_load_en   = 1'b0;
        acc1_load_en = 1'b0;
        acc2_load_en = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_ir_load();
        logic [19:0] exp;
        logic [19:0] obs;
        string       nm;
        @(negedge clk);
        ir_load_en        = 1'b1;
        ir_instruction_in = 20'h1_03_2A;
        exp_q.push_back({16'h0, 20'h1_03_2A});
        name_q.push_back("ir_load");
        @(negedge clk);
        exp = exp_q.pop_front()[19:0];
        nm  = name_q.pop_front();
        obs = {ir_opcode, ir_operand1, ir_operand2};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        ir_load_en        = 1'b0;
        ir_instruction_in = 20'h4_77_55;
        exp_q.push_back({16'h0, 20'h1_03_2A});
        name_q.push_back("ir_hold");
        @(negedge clk);
        @(negedge clk);
        exp = exp_q.pop_front()[19:0];
        nm  = name_q.pop_front();
        obs = {ir_opcode, ir_operand1, ir_operand2};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        ir_load_en = 1'b1;
        exp_q.push_back({16'h0, 20'h4_77_55});
        name_q.push_back("ir_reload_repeat");
        @(negedge clk);
        @(negedge clk);
        exp = exp_q.pop_front()[19:0];
        nm  = name_q.pop_front();
        obs = {ir_opcode, ir_operand1, ir_operand2};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        ir_load_en = 1'b0;
    endtask

    // Applies one ALU vector; expected {result, cout, overflow} is queued first.
    task automatic alu_case(input string nm_in, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] er, input logic ec, input logic ev);
        logic [9:0] exp;
        logic [9:0] obs;
        string      nm;
        exp_q.push_back({26'h0, er, ec, ev});
        name_q.push_back(nm_in);
        alu_op   = op;
        alu_in_a = a;
        alu_in_b = b;
        #1;
        exp = exp_q.pop_front()[9:0];
        nm  = name_q.pop_front();
        obs = {alu_result, alu_cout, alu_overflow};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got r=%h c=%b v=%b expected r=%h c=%b v=%b",
                     nm, obs[9:2], obs[1], obs[0], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic test_alu_add();
        alu_case("add_100_50",  3'd0, 8'd100, 8'd50, 8'h96, 1'b0, 1'b1);
        alu_case("add_ff_01",   3'd0, 8'hFF,  8'h01, 8'h00, 1'b1, 1'b0);
        alu_case("add_80_80",   3'd0, 8'h80,  8'h80, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_alu_sub();
        alu_case("sub_5_7",     3'd1, 8'd5,   8'd7,  8'hFE, 1'b0, 1'b0);
        alu_case("sub_80_01",   3'd1, 8'h80,  8'h01, 8'h7F, 1'b1, 1'b1);
        alu_case("sub_equal",   3'd1, 8'h42,  8'h42, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_alu_logic();
        alu_case("and_cc_aa",   3'd2, 8'hCC,  8'hAA, 8'h88, 1'b0, 1'b0);
        alu_case("or_cc_aa",    3'd3, 8'hCC,  8'hAA, 8'hEE, 1'b0, 1'b0);
        alu_case("xor_cc_aa",   3'd4, 8'hCC,  8'hAA, 8'h66, 1'b0, 1'b0);
        alu_case("nota_cc",     3'd5, 8'hCC,  8'hAA, 8'h33, 1'b0, 1'b0);
    endtask

    task automatic test_alu_shift();
        alu_case("shl_cc",      3'd6, 8'hCC,  8'h00, 8'h98, 1'b1, 1'b0);
        alu_case("shl_40",      3'd6, 8'h40,  8'h00, 8'h80, 1'b0, 1'b1);
        alu_case("shr_81",      3'd7, 8'h81,  8'h00, 8'hC0, 1'b1, 1'b0);
        alu_case("shr_42",      3'd7, 8'h42,  8'h00, 8'h21, 1'b0, 1'b0);
    endtask

    task automatic test_accumulators();
        logic [15:0] exp;
        logic [15:0] obs;
        string       nm;
        @(negedge clk);
        acc1_load_en = 1'b1;
        acc2_load_en = 1'b1;
        acc1_data_in = 8'h5A;
        acc2_data_in = 8'hA5;
        exp_q.push_back({20'h0, 16'h5AA5});
        name_q.push_back("acc_dual_load");
        @(negedge clk);
        exp = exp_q.pop_front()[15:0];
        nm  = name_q.pop_front();
        obs = {acc1_data_out, acc2_data_out};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        acc1_load_en = 1'b0;
        acc1_data_in = 8'h11;
        acc2_data_in = 8'h3C;
        exp_q.push_back({20'h0, 16'h5A3C});
        name_q.push_back("acc1_hold_acc2_load");
        @(negedge clk);
        exp = exp_q.pop_front()[15:0];
        nm  = name_q.pop_front();
        obs = {acc1_data_out, acc2_data_out};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        acc2_load_en = 1'b0;
        acc1_load_en = 1'b1;
        acc2_data_in = 8'h77;
        exp_q.push_back({20'h0, 16'h113C});
        name_q.push_back("acc2_hold_acc1_load");
        @(negedge clk);
        exp = exp_q.pop_front()[15:0];
        nm  = name_q.pop_front();
        obs = {acc1_data_out, acc2_data_out};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        acc1_load_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [35:0] exp;
        logic [35:0] obs;
        string       nm;
        @(negedge clk);
        ir_load_en        = 1'b1;
        acc1_load_en      = 1'b1;
        acc2_load_en      = 1'b1;
        ir_instruction_in = 20'h2_C3_96;
        acc1_data_in      = 8'hDE;
        acc2_data_in      = 8'hAD;
        exp_q.push_back(36'h2_C3_96_DE_AD);
        name_q.push_back("pre_reset_load");
        @(negedge clk);
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        obs = reg_state();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        #2;
        rst_n = 1'b0;
        exp_q.push_back('0);
        name_q.push_back("mid_reset_async");
        #1;
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        obs = reg_state();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        @(negedge clk);
        #2;
        rst_n             = 1'b1;
        ir_instruction_in = 20'h3_01_02;
        acc1_data_in      = 8'h12;
        acc2_data_in      = 8'h34;
        exp_q.push_back(36'h3_01_02_12_34);
        name_q.push_back("reload_after_release");
        @(negedge clk);
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        obs = reg_state();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", nm, obs, exp);
        end
        ir_load_en   = 1'b0;
        acc1_load_en = 1'b0;
        acc2_load_en = 1'b0;
    endtask

    initial begin
        rst_n             = 1'b1;
        ir_load_en        = 1'b0;
        ir_instruction_in = '0;
        alu_in_a          = '0;
        alu_in_b          = '0;
        alu_op            = '0;
        acc1_load_en      = 1'b0;
        acc1_data_in      = '0;
        acc2_load_en      = 1'b0;
        acc2_data_in      = '0;

        test_reset();
        test_ir_load();
        test_alu_add();
        test_alu_sub();
        test_alu_logic();
        test_alu_shift();
        test_accumulators();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cpu_datapath_slice.md
Name: cpu_datapath_slice

Overview:
- Grouped datapath slice of the 8-bit CPU. It holds the 20-bit instruction register with its decoded fields, a combinational 8-bit ALU, and two 8-bit load-enabled accumulators.
- It is driven by the CPU control FSM, which loads instructions fetched from ROM, sets up the ALU operands and opcode in DECODE, and writes back results in EXECUTE.

Parameters:
- DATA_W, 8, width of operands, ALU result and accumulators.
- INSTR_W, 20, instruction width: OPC_W + 2*DATA_W.
- OPC_W, 4, opcode field width.

Ports:
- clk  in  1  rising-edge clock, the single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- ir_load_en  in  1  capture ir_instruction_in on the next rising edge.
- ir_instruction_in  in  20  instruction word from ROM.
- ir_opcode  out  4  registered bits [19:16].
- ir_operand1  out  8  registered bits [15:8]; destination register index or first source.
- ir_operand2  out  8  registered bits [7:0]; second source index or immediate.
- alu_in_a  in  8  signed operand A.
- alu_in_b  in  8  signed operand B.
- alu_op  in  3  ALU operation select.
- alu_result  out  8  ALU result, combinational.
- alu_cout  out  1  carry/no-borrow flag.
- alu_overflow  out  1  signed overflow flag.
- acc1_load_en  in  1  load enable for accumulator 1.
- acc1_data_in  in  8  data for accumulator 1.
- acc1_data_out  out  8  accumulator 1 contents.
- acc2_load_en  in  1  load enable for accumulator 2.
- acc2_data_in  in  8  data for accumulator 2.
- acc2_data_out  out  8  accumulator 2 contents.

Behaviour:
- Reset: rst_n low immediately clears the IR (opcode, operand1, operand2 all 0), acc1_data_out and acc2_data_out, independent of clk.
- ALU outputs are combinational and unaffected by reset.
- Instruction register:
  - On a rising edge with ir_load_en=1, all three fields update together from ir_instruction_in.
  - Latency is 1 cycle; otherwise the register holds.
  - Loading the same word repeatedly is harmless.
- Accumulators:
  - Independent registers, each updating on a rising edge when its own load_en=1; otherwise hold.
  - Both may load in the same cycle.
  - Value is visible on data_out the cycle after the edge.
- ALU: purely combinational, zero-cycle latency. All arithmetic is modulo 2^8.
  - 0 ADD: result = a+b; cout = bit 8 of the unsigned 9-bit sum; overflow = operands share a sign and result sign differs.
  - 1 SUB: result = a-b, computed as a + ~b + 1; cout = 1 when no borrow (unsigned a >= b); overflow = operands differ in sign and result sign differs from a.
  - 2 AND, 3 OR, 4 XOR: bitwise; cout = 0, overflow = 0.
  - 5 NOTA: result = ~a; flags 0.
  - 6 SHL: result = a<<1; cout = a[7]; overflow = a[7]^a[6].
  - 7 SHR: arithmetic right shift by 1; cout = a[0]; overflow = 0.
- alu_op is the low 3 bits of ir_opcode when the control unit forwards it. Opcodes 0-4 therefore map directly onto ALU operations.
- Simultaneous rst_n low with any load: reset wins.
- Reset deasserted mid-operation: registers resume loading on the first rising edge after release.

Decomposition:
- Shared package cpu_pkg holds:
  - widths DATA_W, OPC_W, INSTR_W;
  - opcode constants: ADD=4'h0, SUB=4'h1, AND=4'h2, OR=4'h3, XOR=4'h4, LDR=4'h8, NOP=4'h9, STOP=4'hF;
  - ALU op constants 3'd0..3'd7;
  - instruction field bit positions.
- One natural sub-module, dp_alu, holds the combinational ALU. The IR and accumulators stay inline; the accumulators are two instances of a generate loop or two always blocks.

Test Plan:
- Reset and IR load:
  - Pulse rst_n low with all load enables high: all registered outputs read 0, including asynchronously between edges.
  - Load 20'h1_03_2A: after one edge opcode=1, operand1=0x03, operand2=0x2A.
  - Drop ir_load_en and change the input: the fields hold.
- ADD flags:
  - 100+50: result 0x96, cout 0, overflow 1.
  - 0xFF+0x01: result 0x00, cout 1, overflow 0.
- SUB flags:
  - 5-7: result 0xFE, cout 0, overflow 0.
  - 0x80-0x01: result 0x7F, cout 1, overflow 1.
- Logic ops with a=0xCC, b=0xAA: AND 0x88, OR 0xEE, XOR 0x66, all flags 0.
- Accumulators:
  - acc1 loads 0x5A and acc2 loads 0xA5 on the same edge; both show their values next cycle.
  - acc1_load_en low with acc1_data_in changed: acc1 holds.
- Reset mid-sequence: assert rst_n low between edges after loads. Outputs go to 0 immediately, and the first edge after release with enables high reloads correctly.
